pool_window_2x2: RTL and testbench
==================================

POOL_WINDOW_2X2 -- requirements
Module: pool_window_2x2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width (IEEE-754 single).
REQ-002 SHALL have parameter IMG_WIDTH, default 28, pixels per row (2..1024).
REQ-003 SHALL have parameter IMG_HEIGHT, default 28, rows per frame (2..1024).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port Data_In  input  DATA_WIDTH  pixel, raster order (row-major, top-left first).
REQ-007 SHALL have port Valid_In  input  1  Data_In accepted on every cycle it is high; gaps allowed.
REQ-008 SHALL have port Data_A  output  DATA_WIDTH  window top-left, row 2r col 2c.
REQ-009 SHALL have port Data_B  output  DATA_WIDTH  window top-right, row 2r col 2c+1.
REQ-010 SHALL have port Data_C  output  DATA_WIDTH  window bottom-left, row 2r+1 col 2c.
REQ-011 SHALL have port Data_D  output  DATA_WIDTH  window bottom-right, row 2r+1 col 2c+1.
REQ-012 SHALL have port Valid_Out  output  1  one-cycle pulse, Data_A..Data_D hold a complete window.
REQ-013 SHALL have port Frame_Done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 SHALL form non-overlapping 2x2 windows, stride 2, feeding the downstream max-value stage.
REQ-015 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1), advancing only on accepted pixels; col wraps to 0 and row increments at col=IMG_WIDTH-1; both wrap to 0 after the last pixel.
REQ-016 SHALL use FSM states EVEN_ROW (row even: write pixel to line buffer at address col) and ODD_ROW (row odd: read line buffer, build windows); EVEN_ROW->ODD_ROW at end of even row, ODD_ROW->EVEN_ROW at end of odd row.
REQ-017 SHALL, in ODD_ROW, latch the pixel at even col in a holding register and, on the following odd-col pixel, register A=linebuf[col-1], B=linebuf[col], C=holding, D=Data_In.
REQ-018 SHALL assert Valid_Out exactly one cycle after the accepted pixel completing a window (latency 1), and hold Data_A..Data_D stable until the next window.
REQ-019 SHALL, when IMG_WIDTH is odd, discard the last column (no window, no stall); when IMG_HEIGHT is odd, discard the last row (still counted, never written as a pair).
REQ-020 SHALL assert Frame_Done one cycle after the final pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1); coincides with Valid_Out when that pixel completes a window.
REQ-021 SHALL accept back-to-back frames with no idle cycle; the first pixel of frame N+1 may arrive the cycle after the last of frame N.
REQ-022 SHALL ignore Data_In when Valid_In is low; counters, FSM and holding register unchanged.
REQ-023 SHALL emit (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows per frame (integer division).

Reset
REQ-024 SHALL, on rst high at a rising edge, set col=0, row=0, FSM=EVEN_ROW, Valid_Out=0, Frame_Done=0, Data_A..Data_D=0, holding=0.
REQ-025 SHALL give rst priority over Valid_In; a pixel presented during reset is dropped.
REQ-026 SHALL, after reset mid-frame, treat the next accepted pixel as row 0 col 0; no window combines pre- and post-reset pixels.
REQ-027 SHALL NOT require line-buffer contents to be cleared by reset.

Structure
REQ-028 SHALL take DATA_WIDTH default and FSM state encodings from the shared pooling package/header used by the max-pooling stages.
REQ-029 SHALL instantiate one sub-module pool_line_buffer: single-port-write/async-read RAM, depth IMG_WIDTH, width DATA_WIDTH.
REQ-030 SHALL connect Data_A..Data_D and Valid_Out directly to the downstream max-value stage inputs with no glue logic.

Verification
REQ-031 4x4 frame, pixels 1.0..16.0 continuous -> windows (1,2,5,6),(3,4,7,8),(9,10,13,14),(11,12,15,16), Valid_Out 4 pulses, Frame_Done once after pixel 16.
REQ-032 Same 4x4 frame with Valid_In low every other cycle -> identical windows, each Valid_Out one cycle after its D pixel.
REQ-033 5x3 frame, pixels 1..15 -> exactly 2 windows (1,2,6,7),(3,4,8,9); pixels 5,10,11..15 never appear; Frame_Done after pixel 15.
REQ-034 4x4 frame, rst high for one cycle after pixel 7 then new frame 101..116 -> first window (101,102,105,106), no window from pixels 1..7.
REQ-035 Two 4x4 frames back-to-back (1..16 then 17..32) -> 8 windows, second-frame first window (17,18,21,22), two Frame_Done pulses 16 cycles apart.

Source files
------------

// File: rtl/pool_window_2x2_pkg.sv
// Shared definitions for the 2x2 max-pooling front end.
//   POOL_DATA_WIDTH : default pixel word width (IEEE-754 single precision)
//   row_state_e     : row-parity FSM encoding used by the window former
package pool_window_2x2_pkg;

  localparam int POOL_DATA_WIDTH = 32;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer: synchronous single write port, two asynchronous
// read ports so both top-row pixels of a window are available together.
//   clk       : write clock
//   wr_en     : write strobe
//   wr_addr   : write column
//   wr_data   : pixel to store
//   rd_addr_a : read column for window top-left
//   rd_data_a : stored pixel at rd_addr_a
//   rd_addr_b : read column for window top-right
//   rd_data_b : stored pixel at rd_addr_b
module pool_line_buffer
  import pool_window_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int DEPTH      = 28,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]         rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  // Contents are never cleared: every read column is rewritten by the
  // even row before the odd row that reads it.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_2x2.sv
// Forms non-overlapping 2x2 windows (stride 2) from a raster pixel stream.
// Even rows are stored in a line buffer; odd rows read it back and emit one
// window per odd column, one cycle after the completing pixel.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   Data_In    : pixel, raster order
//   Valid_In   : Data_In accepted when high
//   Data_A..D  : window top-left, top-right, bottom-left, bottom-right
//   Valid_Out  : one-cycle pulse, Data_A..D hold a new window
//   Frame_Done : one-cycle pulse after the last pixel of a frame
module pool_window_2x2
  import pool_window_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDTH-1:0] Data_A,
  output logic [DATA_WIDTH-1:0] Data_B,
  output logic [DATA_WIDTH-1:0] Data_C,
  output logic [DATA_WIDTH-1:0] Data_D,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  row_state_e            state, state_nxt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  last_col, last_row;
  logic                  wr_en, hold_en, win_en;
  logic [DATA_WIDTH-1:0] hold_p0;
  logic [DATA_WIDTH-1:0] lb_a, lb_b;
  logic                  vld_p1, done_p1;

  pool_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_WIDTH)
  ) u_line_buffer (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (col),
    .wr_data  (Data_In),
    .rd_addr_a(col - CW'(1)),
    .rd_data_a(lb_a),
    .rd_addr_b(col),
    .rd_data_b(lb_b)
  );

  always_comb begin
    last_col  = (col == CW'(IMG_WIDTH - 1));
    last_row  = (row == RW'(IMG_HEIGHT - 1));
    state_nxt = state;
    wr_en     = 1'b0;
    hold_en   = 1'b0;
    win_en    = 1'b0;
    case (state)
      EVEN_ROW: begin
        wr_en = Valid_In && !rst;
        // A trailing even row (odd height) wraps straight to the next frame.
        if (Valid_In && last_col && !last_row) begin
          state_nxt = ODD_ROW;
        end
      end
      ODD_ROW: begin
        // An even last column (odd width) is only ever held, never paired.
        hold_en = Valid_In && !col[0];
        win_en  = Valid_In && col[0];
        if (Valid_In && last_col) begin
          state_nxt = EVEN_ROW;
        end
      end
      default: state_nxt = EVEN_ROW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EVEN_ROW;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0 -> p1: counters, holding register, registered window
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      hold_p0 <= '0;
      Data_A  <= '0;
      Data_B  <= '0;
      Data_C  <= '0;
      Data_D  <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= win_en;
      done_p1 <= Valid_In && last_col && last_row;
      if (Valid_In) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (hold_en) begin
        hold_p0 <= Data_In;
      end
      if (win_en) begin
        Data_A <= lb_a;
        Data_B <= lb_b;
        Data_C <= hold_p0;
        Data_D <= Data_In;
      end
    end
  end

  assign Valid_Out  = vld_p1;
  assign Frame_Done = done_p1;

endmodule

// File: tb/tb_pool_window_2x2.sv
module tb_pool_window_2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       vin;
  logic [1:0][31:0] din;
  logic [1:0][31:0] qa, qb, qc, qd;
  logic [1:0]       vout, fdone;

  // Channel 0: 4x4 image, channel 1: 5x3 image (odd width and height)
  pool_window_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .Data_In(din[0]), .Valid_In(vin[0]),
    .Data_A(qa[0]), .Data_B(qb[0]), .Data_C(qc[0]), .Data_D(qd[0]),
    .Valid_Out(vout[0]), .Frame_Done(fdone[0])
  );

  pool_window_2x2 #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut53 (
    .clk(clk), .rst(rst), .Data_In(din[1]), .Valid_In(vin[1]),
    .Data_A(qa[1]), .Data_B(qb[1]), .Data_C(qc[1]), .Data_D(qd[1]),
    .Valid_Out(vout[1]), .Frame_Done(fdone[1])
  );

  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  int   cyc = 0;
  logic [127:0] obs0[$];
  logic [127:0] obs1[$];
  int   dn0[$];
  int   dn1[$];

  // Small positive integer to IEEE-754 single
  function automatic logic [31:0] f32(input int n);
    int e;
    int mant;
    e = 0;
    for (int i = 0; i < 31; i++) if ((n >> i) != 0) e = i;
    mant = (n << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), mant[22:0]};
  endfunction

  function automatic logic [127:0] win(input int a, input int b, input int c, input int d);
    return {f32(a), f32(b), f32(c), f32(d)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_w(input string nm, input int ch, input int idx, input logic [127:0] exp);
    logic [127:0] act;
    act = '1;
    if (ch == 0 && idx < obs0.size()) act = obs0[idx];
    if (ch == 1 && idx < obs1.size()) act = obs1[idx];
    chk(nm, act, exp);
  endtask

  // Reference model plus per-cycle comparison. At each rising edge the
  // model consumes the same inputs the DUTs see and works out, from the
  // pixel's (row, col) position in the frame, what the outputs must be
  // during the following cycle; those are checked at the falling edge.
  initial begin
    int               pc [2];
    logic [31:0]      frm [2][32];
    logic [1:0]       ev, ed;
    logic [1:0][127:0] ew;
    int               w, h, r, c;
    pc = '{0, 0};
    ev = '0;
    ed = '0;
    ew = '0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        w = (k == 0) ? 4 : 5;
        h = (k == 0) ? 4 : 3;
        ev[k] = 1'b0;
        ed[k] = 1'b0;
        if (rst) begin
          pc[k] = 0;
          ew[k] = '0;
        end else if (vin[k]) begin
          r = pc[k] / w;
          c = pc[k] % w;
          frm[k][pc[k]] = din[k];
          if (r % 2 == 1 && c % 2 == 1) begin
            ev[k] = 1'b1;
            ew[k] = {frm[k][(r-1)*w + c-1], frm[k][(r-1)*w + c], frm[k][r*w + c-1], din[k]};
          end
          if (pc[k] == w*h - 1) begin
            ed[k] = 1'b1;
            pc[k] = 0;
          end else begin
            pc[k]++;
          end
        end
      end
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("valid_out_ch%0d", k), 128'(vout[k]), 128'(ev[k]));
          chk($sformatf("frame_done_ch%0d", k), 128'(fdone[k]), 128'(ed[k]));
          chk($sformatf("window_ch%0d", k), {qa[k], qb[k], qc[k], qd[k]}, ew[k]);
        end
      end
      if (vout[0] === 1'b1) obs0.push_back({qa[0], qb[0], qc[0], qd[0]});
      if (vout[1] === 1'b1) obs1.push_back({qa[1], qb[1], qc[1], qd[1]});
      if (fdone[0] === 1'b1) dn0.push_back(cyc);
      if (fdone[1] === 1'b1) dn1.push_back(cyc);
    end
  end

  task automatic step(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    vin[0] = v0;
    din[0] = d0;
    vin[1] = v1;
    din[1] = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic clear_obs();
    obs0.delete();
    obs1.delete();
    dn0.delete();
    dn1.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    vin = '0;
    din = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 4x4 continuous
    clear_obs();
    for (int i = 1; i <= 16; i++) step(1'b1, f32(i), 1'b0, '0);
    idle(3);
    chk("t1_count", 128'(obs0.size()), 128'(4));
    chk_w("t1_win0", 0, 0, win(1, 2, 5, 6));
    chk_w("t1_win1", 0, 1, win(3, 4, 7, 8));
    chk_w("t1_win2", 0, 2, win(9, 10, 13, 14));
    chk_w("t1_win3", 0, 3, win(11, 12, 15, 16));
    chk("t1_done_count", 128'(dn0.size()), 128'(1));

    // 4x4 with a gap after every pixel
    clear_obs();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, f32(i), 1'b0, '0);
      step(1'b0, 32'hDEAD_BEEF, 1'b0, '0);
    end
    idle(3);
    chk("t2_count", 128'(obs0.size()), 128'(4));
    chk_w("t2_win0", 0, 0, win(1, 2, 5, 6));
    chk_w("t2_win3", 0, 3, win(11, 12, 15, 16));
    chk("t2_done_count", 128'(dn0.size()), 128'(1));

    // 5x3: last column and last row discarded
    clear_obs();
    for (int i = 1; i <= 15; i++) step(1'b0, '0, 1'b1, f32(i));
    idle(3);
    chk("t3_count", 128'(obs1.size()), 128'(2));
    chk_w("t3_win0", 1, 0, win(1, 2, 6, 7));
    chk_w("t3_win1", 1, 1, win(3, 4, 8, 9));
    chk("t3_done_count", 128'(dn1.size()), 128'(1));

    // Reset mid-frame; pixel presented during reset is dropped
    clear_obs();
    for (int i = 1; i <= 7; i++) step(1'b1, f32(i), 1'b0, '0);
    rst = 1'b1;
    step(1'b1, f32(8), 1'b0, '0);
    rst = 1'b0;
    clear_obs();
    for (int i = 101; i <= 116; i++) step(1'b1, f32(i), 1'b0, '0);
    idle(3);
    chk("t4_count", 128'(obs0.size()), 128'(4));
    chk_w("t4_win0", 0, 0, win(101, 102, 105, 106));
    chk_w("t4_win3", 0, 3, win(111, 112, 115, 116));
    chk("t4_done_count", 128'(dn0.size()), 128'(1));

    // Two frames back-to-back
    clear_obs();
    for (int i = 1; i <= 32; i++) step(1'b1, f32(i), 1'b0, '0);
    idle(3);
    chk("t5_count", 128'(obs0.size()), 128'(8));
    chk_w("t5_win4", 0, 4, win(17, 18, 21, 22));
    chk_w("t5_win7", 0, 7, win(27, 28, 31, 32));
    chk("t5_done_count", 128'(dn0.size()), 128'(2));
    if (dn0.size() == 2) chk("t5_done_gap", 128'(dn0[1] - dn0[0]), 128'(16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
